smm_seq_strassen: RTL and testbench
===================================

// Module: smm_seq_strassen
// PURPOSE
//   Parametrised, resource-shared Strassen matrix multiplier: C = A*B (or C += A*B) for
//   signed NxN matrices, N = 2*BLK, split into 2x2 blocks of BLKxBLK. A single internal
//   BLK-term dot-product unit computes the seven Strassen products M0..M6 in turn, then
//   one combine cycle forms C. Valid/ready on both sides; drop-in for the 4x4 datapath at BLK=2.
// PARAMETERS
//   DATAWIDTH  32  element width, signed two's complement; all arithmetic wraps mod 2^DATAWIDTH
//   BLK        2   block dimension (>=1); N = 2*BLK; BUSWIDTH = N*N*DATAWIDTH (512 at defaults)
// PORTS
//   clk       in   1         clock; single clock domain, all state on rising edge
//   rst       in   1         synchronous reset, active-high
//   in_valid  in   1         A/B/acc_en valid
//   in_ready  out  1         block can accept a job (high only in IDLE)
//   A, B      in   BUSWIDTH  row-major; element (r,c) at [(r*N+c)*DATAWIDTH +: DATAWIDTH]
//   acc_en    in   1         sampled with job: 1 -> C_out <= C_out + A*B, 0 -> C_out <= A*B
//   out_valid out  1         C_out holds a finished result
//   out_ready in   1         consumer takes result
//   C_out     out  BUSWIDTH  result, same packing as A/B; holds value after handshake
//   busy      out  1         high in PROD or COMB
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, C_out=0, out_valid=0, counters/M store=0; in_ready=1
//   after. Reset mid-job aborts it; no partial result ever appears on C_out.
//   FSM: IDLE -(in_valid&in_ready)-> PROD -(last element of M6)-> COMB -> DONE -(out_ready)-> IDLE.
//   IDLE: accept edge latches A, B, acc_en into internal regs; inputs may change afterwards.
//   PROD: counters p=0..6, r,c=0..BLK-1 (c fastest, then r, then p). Each cycle forms
//     row r of T_p and column c of S_p from latched blocks (A00..A11/B00..B11) and writes
//     M_p[r][c] = sum_k T_p[r][k]*S_p[k][c], truncated to DATAWIDTH. Exactly 7*BLK^2 cycles.
//     T0=A00+A11 S0=B00+B11 | T1=A10+A11 S1=B00 | T2=A00 S2=B01-B11 | T3=A11 S3=B10-B00
//     T4=A00+A01 S4=B11 | T5=A10-A00 S5=B00+B01 | T6=A01-A11 S6=B10+B11
//   COMB (1 cycle): C00=M0+M3-M4+M6, C01=M2+M4, C10=M1+M3, C11=M0-M1+M2+M5;
//     C_out <= acc ? C_out+C : C (elementwise, wrapping); out_valid<=1.
//   Latency: out_valid rises on edge 7*BLK^2+1 after the accept edge (29 at BLK=2).
//   DONE: out_valid and C_out stable until out_ready=1 sampled; that edge clears out_valid,
//     returns to IDLE. out_ready while not DONE is ignored. No new job accepted in DONE.
//   in_valid while busy is ignored (in_ready=0); producer must hold until handshake.
//   Throughput: one job per 7*BLK^2+3 cycles minimum (accept, PROD, COMB, DONE handshake).
//   Overflow: intermediate sums/products wrap silently; result equals wrap of exact A*B.
// TESTING
//   1 rst 2 cycles; A=I4, B=rows{1..16}, acc_en=0 (BLK=2) -> out_valid on edge 29, C_out=B
//   2 A=all 2, B=all 3, acc_en=0 then same job acc_en=1 -> C elems 24, then 48
//   3 A=B=[[1,2,3,4]..] with negatives (-7,5) vs golden model; hold out_ready=0 20 cycles ->
//     C_out/out_valid stable, in_ready=0, second in_valid ignored
//   4 A=B=all 0x7FFFFFFF -> each C elem = (4*(2^31-1)^2) mod 2^32 = 4, no X
//   5 assert rst at cycle 10 of PROD -> next cycle out_valid=0, C_out=0, in_ready=1; new job correct
//   6 BLK=1 and BLK=4, DATAWIDTH=16, 200 random jobs vs model; latencies 8 and 113

Source files
------------

// File: rtl/smm_seq_strassen.sv
// Resource-shared Strassen NxN multiplier (N = 2*BLK): one BLK-term dot-product unit
// evaluates M0..M6 element by element, then a single combine cycle forms/accumulates C.
module smm_seq_strassen #(
    parameter  int DATAWIDTH = 32,
    parameter  int BLK       = 2,
    localparam int N         = 2 * BLK,
    localparam int BUSWIDTH  = N * N * DATAWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUSWIDTH-1:0] A,
    input  logic [BUSWIDTH-1:0] B,
    input  logic                acc_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUSWIDTH-1:0] C_out,
    output logic                busy
);
    localparam int BB = BLK * BLK;
    localparam int RW = (BLK > 1) ? $clog2(BLK) : 1;

    typedef logic [DATAWIDTH-1:0] elem_t;
    typedef enum logic [1:0] {IDLE, PROD, COMB, DONE} state_t;

    state_t                state;
    elem_t [N*N-1:0]       a_q, b_q, c_q, cres;
    elem_t [6:0][BB-1:0]   m_q;
    logic                  acc_q;
    logic [2:0]            p;
    logic [RW-1:0]         r, c;
    elem_t                 dot;
    elem_t                 a00, a01, a10, a11, b00, b01, b10, b11, t, s;

    assign in_ready = (state == IDLE);
    assign busy     = (state == PROD) || (state == COMB);
    assign C_out    = c_q;

    // Row r of T_p dotted with column c of S_p, built from the latched quadrants.
    always_comb begin
        int ri, ci;
        ri  = int'(r);
        ci  = int'(c);
        dot = '0;
        a00 = '0; a01 = '0; a10 = '0; a11 = '0;
        b00 = '0; b01 = '0; b10 = '0; b11 = '0;
        t   = '0; s   = '0;
        for (int k = 0; k < BLK; k++) begin
            a00 = a_q[ri*N + k];
            a01 = a_q[ri*N + BLK + k];
            a10 = a_q[(BLK+ri)*N + k];
            a11 = a_q[(BLK+ri)*N + BLK + k];
            b00 = b_q[k*N + ci];
            b01 = b_q[k*N + BLK + ci];
            b10 = b_q[(BLK+k)*N + ci];
            b11 = b_q[(BLK+k)*N + BLK + ci];
            case (p)
                3'd0:    begin t = a00 + a11; s = b00 + b11; end
                3'd1:    begin t = a10 + a11; s = b00;       end
                3'd2:    begin t = a00;       s = b01 - b11; end
                3'd3:    begin t = a11;       s = b10 - b00; end
                3'd4:    begin t = a00 + a01; s = b11;       end
                3'd5:    begin t = a10 - a00; s = b00 + b01; end
                3'd6:    begin t = a01 - a11; s = b10 + b11; end
                default: begin t = '0;        s = '0;        end
            endcase
            dot = dot + t * s;
        end
    end

    always_comb begin
        cres = '0;
        for (int rr = 0; rr < BLK; rr++) begin
            for (int cc = 0; cc < BLK; cc++) begin
                cres[rr*N + cc]             = m_q[0][rr*BLK+cc] + m_q[3][rr*BLK+cc]
                                            - m_q[4][rr*BLK+cc] + m_q[6][rr*BLK+cc];
                cres[rr*N + BLK + cc]       = m_q[2][rr*BLK+cc] + m_q[4][rr*BLK+cc];
                cres[(BLK+rr)*N + cc]       = m_q[1][rr*BLK+cc] + m_q[3][rr*BLK+cc];
                cres[(BLK+rr)*N + BLK + cc] = m_q[0][rr*BLK+cc] - m_q[1][rr*BLK+cc]
                                            + m_q[2][rr*BLK+cc] + m_q[5][rr*BLK+cc];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            m_q       <= '0;
            acc_q     <= 1'b0;
            p         <= '0;
            r         <= '0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= A;
                    b_q   <= B;
                    acc_q <= acc_en;
                    p     <= '0;
                    r     <= '0;
                    c     <= '0;
                    state <= PROD;
                end
                PROD: begin
                    m_q[p][int'(r)*BLK + int'(c)] <= dot;
                    // c fastest, then r, then p; the last M6 element hands over to COMB
                    if (c == RW'(BLK-1)) begin
                        c <= '0;
                        if (r == RW'(BLK-1)) begin
                            r <= '0;
                            if (p == 3'd6) begin
                                p     <= '0;
                                state <= COMB;
                            end else begin
                                p <= p + 3'd1;
                            end
                        end else begin
                            r <= r + RW'(1);
                        end
                    end else begin
                        c <= c + RW'(1);
                    end
                end
                COMB: begin
                    for (int i = 0; i < N*N; i++)
                        c_q[i] <= acc_q ? c_q[i] + cres[i] : cres[i];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smm_seq_strassen.sv
// Directed and random checks of smm_seq_strassen at BLK=2/DW=32 plus BLK=1 and BLK=4 at DW=16.
module tb_smm_seq_strassen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 0, out_ready = 0, acc_en = 0;
    logic         in_ready, out_valid, busy;
    logic [511:0] A = '0, B = '0, C;

    logic         iv1 = 0, or1 = 0, ae1 = 0, ir1, ov1, bz1;
    logic [63:0]  a1 = '0, b1 = '0, c1;
    logic         iv4 = 0, or4 = 0, ae4 = 0, ir4, ov4, bz4;
    logic [1023:0] a4 = '0, b4 = '0, c4;

    smm_seq_strassen #(.DATAWIDTH(32), .BLK(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .acc_en(acc_en), .out_valid(out_valid), .out_ready(out_ready), .C_out(C), .busy(busy));
    smm_seq_strassen #(.DATAWIDTH(16), .BLK(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
        .acc_en(ae1), .out_valid(ov1), .out_ready(or1), .C_out(c1), .busy(bz1));
    smm_seq_strassen #(.DATAWIDTH(16), .BLK(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
        .acc_en(ae4), .out_valid(ov4), .out_ready(or4), .C_out(c4), .busy(bz4));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [511:0] a;
        logic [511:0] b;
        logic         acc;
        logic [511:0] want;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [511:0] mm32(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] res;
        logic [31:0]  acc;
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) acc = acc + a[(r*4+k)*32 +: 32] * b[(k*4+c)*32 +: 32];
                res[(r*4+c)*32 +: 32] = acc;
            end
        return res;
    endfunction

    function automatic logic [1023:0] mm16(input logic [1023:0] a, input logic [1023:0] b, input int n);
        logic [1023:0] res;
        logic [15:0]   acc;
        res = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                acc = '0;
                for (int k = 0; k < n; k++) acc = acc + a[(r*n+k)*16 +: 16] * b[(k*n+c)*16 +: 16];
                res[(r*n+c)*16 +: 16] = acc;
            end
        return res;
    endfunction

    function automatic logic [1023:0] add16(input logic [1023:0] x, input logic [1023:0] y, input int n);
        logic [1023:0] res;
        res = '0;
        for (int i = 0; i < n*n; i++) res[i*16 +: 16] = x[i*16 +: 16] + y[i*16 +: 16];
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one job on the BLK=2 instance and return edges from accept to out_valid.
    task automatic run_job32(input logic [511:0] a, input logic [511:0] b, input logic acc,
                             output int lat);
        A = a; B = b; acc_en = acc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        A = ~a; B = ~b; acc_en = ~acc;
        chk("busy_after_accept", {510'd0, busy, in_ready}, 512'd2);
        lat = 0;
        while (!out_valid && lat < 300) begin
            step();
            lat++;
        end
    endtask

    task automatic release32();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_ov", {511'd0, out_valid}, 512'd0);
    endtask

    task automatic run_small(input int blk, input int njobs);
        int n, lat, elat;
        logic [1023:0] a, b, prod, want, prev;
        logic acc, ov;
        n = 2 * blk;
        elat = 7 * blk * blk + 1;
        prev = '0;
        for (int j = 0; j < njobs; j++) begin
            a = '0; b = '0;
            for (int i = 0; i < n*n; i++) begin
                a[i*16 +: 16] = 16'($urandom);
                b[i*16 +: 16] = 16'($urandom);
            end
            acc  = 1'($urandom_range(0, 1));
            prod = mm16(a, b, n);
            want = acc ? add16(prev, prod, n) : prod;
            if (blk == 1) begin
                chk("s1_ready", {511'd0, ir1}, 512'd1);
                a1 = a[63:0]; b1 = b[63:0]; ae1 = acc; iv1 = 1'b1;
            end else begin
                chk("s4_ready", {511'd0, ir4}, 512'd1);
                a4 = a; b4 = b; ae4 = acc; iv4 = 1'b1;
            end
            step();
            iv1 = 1'b0; iv4 = 1'b0;
            chk("s_busy", {511'd0, (blk == 1) ? bz1 : bz4}, 512'd1);
            lat = 0;
            ov  = (blk == 1) ? ov1 : ov4;
            while (!ov && lat < 300) begin
                step();
                lat++;
                ov = (blk == 1) ? ov1 : ov4;
            end
            chk("s_latency", 512'(lat), 512'(elat));
            if (blk == 1) begin
                chk("s1_c", {448'd0, c1}, {448'd0, want[63:0]});
                or1 = 1'b1;
            end else begin
                chk("s4_c_lo", c4[511:0], want[511:0]);
                chk("s4_c_hi", c4[1023:512], want[1023:512]);
                or4 = 1'b1;
            end
            step();
            or1 = 1'b0; or4 = 1'b0;
            prev = want;
        end
    endtask

    initial begin
        int lat, bad;
        int m3[16];
        logic [511:0] all2, all3, all24, all48, allmax, all4, ident, rows, neg, want3;

        m3 = '{1, 2, 3, 4, 5, -7, 6, 8, -1, 0, 2, 3, 4, 5, -2, 1};
        ident = '0;
        for (int i = 0; i < 16; i++) begin
            all2[i*32 +: 32]   = 32'd2;
            all3[i*32 +: 32]   = 32'd3;
            all24[i*32 +: 32]  = 32'd24;
            all48[i*32 +: 32]  = 32'd48;
            allmax[i*32 +: 32] = 32'h7FFF_FFFF;
            all4[i*32 +: 32]   = 32'd4;
            rows[i*32 +: 32]   = 32'(i + 1);
            neg[i*32 +: 32]    = 32'(m3[i]);
        end
        for (int i = 0; i < 4; i++) ident[(i*4+i)*32 +: 32] = 32'd1;
        want3 = mm32(neg, neg);

        vt[0] = '{a: ident,  b: rows,   acc: 1'b0, want: rows};
        vt[1] = '{a: all2,   b: all3,   acc: 1'b0, want: all24};
        vt[2] = '{a: all2,   b: all3,   acc: 1'b1, want: all48};
        vt[3] = '{a: neg,    b: neg,    acc: 1'b0, want: want3};
        vt[4] = '{a: allmax, b: allmax, acc: 1'b0, want: all4};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_c", C, '0);
        chk("reset_flags", {508'd0, out_valid, busy, in_ready, 1'b0}, 512'd2);

        for (int v = 0; v < 5; v++) begin
            run_job32(vt[v].a, vt[v].b, vt[v].acc, lat);
            chk($sformatf("vec%0d_latency", v), 512'(lat), 512'd29);
            chk($sformatf("vec%0d_c", v), C, vt[v].want);
            release32();
            chk($sformatf("vec%0d_c_held", v), C, vt[v].want);
        end

        // Back-pressure: result must hold, and a job offered during DONE must be ignored.
        run_job32(neg, neg, 1'b0, lat);
        chk("hold_latency", 512'(lat), 512'd29);
        A = all2; B = all3; acc_en = 1'b0; in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (C !== want3 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        chk("hold_stable", 512'(bad), 512'd0);
        in_valid = 1'b0;
        release32();
        chk("hold_ready_after", {511'd0, in_ready}, 512'd1);
        bad = 0;
        for (int i = 0; i < 35; i++) begin
            step();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("ignored_job_absent", 512'(bad), 512'd0);
        chk("ignored_c_kept", C, want3);

        // Reset in the middle of PROD.
        A = all2; B = all3; acc_en = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_c", C, '0);
        chk("midrst_flags", {509'd0, out_valid, busy, in_ready}, 512'd1);
        run_job32(ident, rows, 1'b1, lat);
        chk("postrst_latency", 512'(lat), 512'd29);
        chk("postrst_c", C, rows);
        release32();

        run_small(1, 200);
        run_small(4, 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
